// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM arbiter.
package vram_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RDATA} state_e;

  localparam int DEF_AW         = 12;
  localparam int DEF_DW         = 8;
  localparam int DEF_STARVE_MAX = 4;

  // Bank-select width; a single bank still carries one select bit.
  function automatic int bank_bits(input int nbanks);
    return (nbanks > 1) ? $clog2(nbanks) : 1;
  endfunction

endpackage

// File: rtl/vram_bank_mux.sv
// Per-bank port mux: the CPU owns the bank only in its grant slot, otherwise
// the render fetch drives it. Also produces the render valid/stall flags.
module vram_bank_mux #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          vdc_req,
  input  logic [AW-1:0] vdc_a,
  input  logic          cpu_sel,
  input  logic          cpu_rd,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_di,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_di,
  output logic          mem_rd_n,
  output logic          mem_wr_n,
  output logic          vdc_valid,
  output logic          vdc_stall
);

  // cpu_sel already includes the enable, so a grant with a live render
  // request can only be the forced one.
  assign vdc_stall = vdc_req && cpu_sel;
  assign mem_a     = cpu_sel ? cpu_a : vdc_a;
  assign mem_di    = cpu_di;
  assign mem_rd_n  = cpu_sel ? !cpu_rd : !(en && vdc_req);
  assign mem_wr_n  = !(cpu_sel && !cpu_rd);

  // Render data is valid one CE cycle after an accepted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  vdc_valid <= 1'b0;
    else if (en) vdc_valid <= vdc_req && !vdc_stall;
  end

endmodule

// File: rtl/vram_arb.sv
// N-bank VRAM arbiter: render fetch has slot priority, the CPU command waits
// in a one-entry register and is force-granted after STARVE_MAX CE cycles.
module vram_arb import vram_pkg::*; #(
  parameter  int NBANKS     = 2,
  parameter  int AW         = DEF_AW,
  parameter  int DW         = DEF_DW,
  parameter  int STARVE_MAX = DEF_STARVE_MAX,
  localparam int BW         = bank_bits(NBANKS)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 CE,
  input  logic [AW+BW-1:0]     CPU_A,
  input  logic [DW-1:0]        CPU_DI,
  output logic [DW-1:0]        CPU_DO,
  input  logic                 CPU_RD,
  input  logic                 CPU_WR,
  output logic                 CPU_BUSY,
  input  logic [NBANKS-1:0]    VDC_REQ,
  input  logic [NBANKS*AW-1:0] VDC_A,
  output logic [NBANKS*DW-1:0] VDC_DO,
  output logic [NBANKS-1:0]    VDC_VALID,
  output logic [NBANKS-1:0]    VDC_STALL,
  output logic [NBANKS*AW-1:0] MEM_A,
  output logic [NBANKS*DW-1:0] MEM_DI,
  input  logic [NBANKS*DW-1:0] MEM_DO,
  output logic [NBANKS-1:0]    nMEM_RD,
  output logic [NBANKS-1:0]    nMEM_WR
);

  state_e            state;
  logic [AW+BW-1:0]  cmd_a;
  logic [DW-1:0]     cmd_d;
  logic              cmd_rd;
  logic [3:0]        starve;
  logic [BW-1:0]     tgt;
  logic              tgt_ok;
  logic              en;
  logic [NBANKS-1:0] gnt;
  logic              grant;
  logic [DW-1:0]     rd_mux;

  // Strobes are inactive while CE is low or reset is asserted.
  assign en     = CE && nRST;
  assign tgt    = cmd_a[AW+BW-1 -: BW];
  assign tgt_ok = ({1'b0, tgt} < (BW+1)'(NBANKS));
  assign grant  = |gnt;
  assign VDC_DO = MEM_DO;

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    assign gnt[b] = en && (state == WAIT) && tgt_ok && (tgt == BW'(b)) &&
                    (!VDC_REQ[b] || starve == 4'(STARVE_MAX));

    vram_bank_mux #(.AW(AW), .DW(DW)) u_mux (
      .clk       (CLK),
      .rst_n     (nRST),
      .en        (en),
      .vdc_req   (VDC_REQ[b]),
      .vdc_a     (VDC_A[b*AW +: AW]),
      .cpu_sel   (gnt[b]),
      .cpu_rd    (cmd_rd),
      .cpu_a     (cmd_a[AW-1:0]),
      .cpu_di    (cmd_d),
      .mem_a     (MEM_A[b*AW +: AW]),
      .mem_di    (MEM_DI[b*DW +: DW]),
      .mem_rd_n  (nMEM_RD[b]),
      .mem_wr_n  (nMEM_WR[b]),
      .vdc_valid (VDC_VALID[b]),
      .vdc_stall (VDC_STALL[b])
    );
  end

  // Read-back select for the target bank; an out-of-range bank reads all-ones.
  always_comb begin
    rd_mux = '1;
    for (int b = 0; b < NBANKS; b++)
      if (tgt == BW'(b)) rd_mux = MEM_DO[b*DW +: DW];
  end

  // Command FSM with starvation counter; BUSY mirrors "state != IDLE".
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      CPU_BUSY <= 1'b0;
      CPU_DO   <= '0;
      cmd_a    <= '0;
      cmd_d    <= '0;
      cmd_rd   <= 1'b0;
      starve   <= '0;
    end else if (CE) begin
      case (state)
        IDLE: if (CPU_RD || CPU_WR) begin
          cmd_a    <= CPU_A;
          cmd_d    <= CPU_DI;
          cmd_rd   <= CPU_RD;
          starve   <= '0;
          state    <= WAIT;
          CPU_BUSY <= 1'b1;
        end
        WAIT: begin
          if (!tgt_ok) begin
            if (cmd_rd) CPU_DO <= '1;
            state    <= IDLE;
            CPU_BUSY <= 1'b0;
          end else if (grant) begin
            starve <= '0;
            if (cmd_rd) state <= RDATA;
            else begin
              state    <= IDLE;
              CPU_BUSY <= 1'b0;
            end
          end else if (starve != 4'(STARVE_MAX)) begin
            starve <= starve + 4'd1;
          end
        end
        RDATA: begin
          CPU_DO   <= rd_mux;
          state    <= IDLE;
          CPU_BUSY <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          CPU_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule
